amber_mem_dp: RTL and testbench
===============================

// Module: amber_mem_dp
// PURPOSE
//   Parametrised dual-port word memory, successor to the single-port 48-bit
//   store. Port A is read-only (instruction fetch); port B is read/write with
//   per-byte lane enables (data). Reads are registered with 1-cycle latency and
//   a valid strobe. A built-in clear FSM zeroes the array after every reset.
// PARAMETERS
//   WIDTH   48     data width in bits; must be a multiple of 8
//   WORDS   16384  depth in words; need not be a power of two
//   LANES   WIDTH/8  byte lanes (derived, do not override)
//   ADDR_W  $clog2(WORDS)  address width (derived)
// PORTS
//   clk       in   1       clock, all logic on posedge
//   rst_n     in   1       synchronous active-low reset
//   busy      out  1       1 while the clear FSM runs
//   a_req     in   1       port A read request
//   a_ready   out  1       port A accepts (= !busy)
//   a_addr    in   ADDR_W  port A word index
//   a_rvalid  out  1       port A read data valid (1-cycle pulse)
//   a_rdata   out  WIDTH   port A read data
//   a_perr    out  1       port A parity error, qualified by a_rvalid
//   b_req     in   1       port B request
//   b_ready   out  1       port B accepts (= !busy)
//   b_we      in   1       1 = write, 0 = read
//   b_be      in   LANES   lane write enables (bit i -> bits 8i+7:8i)
//   b_addr    in   ADDR_W  port B word index
//   b_wdata   in   WIDTH   port B write data
//   b_rvalid  out  1       port B read data valid (reads only)
//   b_rdata   out  WIDTH   port B read data
//   b_perr    out  1       port B parity error, qualified by b_rvalid
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): a/b_rvalid=0, a/b_rdata=0, a/b_perr=0, busy=1,
//     state=CLEAR, clr_addr=0. Reset asserted mid-clear restarts from 0.
//   FSM: CLEAR -> RUN. CLEAR writes 0 (and zero parity) to clr_addr, one word
//     per cycle; clr_addr==WORDS-1 -> RUN next cycle. Clear takes WORDS cycles.
//     RUN is terminal until reset. Requests during CLEAR are ignored (ready=0).
//   Accept = req & ready. A read accepted in cycle N gives rvalid=1 and rdata in
//     cycle N+1; rdata/perr hold until the next accepted read on that port.
//   B write: lanes with b_be[i]=1 are updated at the posedge; other lanes keep
//     their value; b_be=0 is a no-op. Writes produce no rvalid.
//   Collision, same cycle, same address, A read + B write: A returns
//     write-first data (enabled lanes from b_wdata, other lanes old data).
//   B read of an address written by B in the previous cycle sees the new data.
//   addr >= WORDS (non-power-of-two depth): read returns 0, perr=0; write is
//     dropped. Both ports are fully independent; back-to-back reads every cycle
//     are allowed (throughput 1/cycle/port).
// CONFIGURATION
//   AMBER_MEM_PARITY_EN defined: one even-parity bit stored per lane (array
//     WIDTH+LANES wide); written with each lane; recomputed on read; perr=1 if
//     any lane mismatches. Forwarded collision data reports perr=0.
//   Undefined: no parity storage; a_perr and b_perr are tied to 0.
// STRUCTURE
//   Package amber_mem_pkg: state enum {CLEAR, RUN}, LANE_W=8, function
//     lane_parity(WIDTH data) -> LANES bits.
//   One sub-module: amber_mem_lane_merge (old word, new word, be -> merged
//     word), shared by write path and collision forwarding.
//   Top holds the array, clear FSM, and both read pipelines.
// TESTING
//   1 Reset, WORDS=16: busy=1 for exactly 16 cycles, ready=0; then A read of
//     addr 5 -> a_rvalid next cycle, a_rdata=0.
//   2 B write addr 3, be=6'h3F, data 48'hA5A5_1234_5678; B read addr 3 next
//     cycle -> b_rdata=48'hA5A5_1234_5678, one cycle after accept.
//   3 Partial write addr 3, be=6'b000001, data 48'hFF -> read 48'hA5A5_1234_56FF.
//   4 Same cycle: A read addr 7 (holds 0) + B write addr 7 be=6'b110000,
//     data 48'hBEEF_0000_0000 -> a_rdata=48'hBEEF_0000_0000.
//   5 WORDS=12: B write addr 13 then read addr 13 -> b_rdata=0; addr 0..11
//     unchanged. Reset asserted at clear cycle 5 -> busy lasts 12 more cycles.
//   6 AMBER_MEM_PARITY_EN: flip stored bit 9 of addr 2 hierarchically, read
//     addr 2 -> b_perr=1 with b_rvalid; without the macro b_perr stays 0.

Source files
------------

// File: rtl/amber_mem_pkg.sv
// amber_mem_pkg: shared clear-FSM state type, lane width and per-lane even-parity helper for amber_mem_dp
package amber_mem_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  localparam int LANE_W = 8;
  localparam int MAX_W = 512;
  function automatic logic [MAX_W/LANE_W-1:0] lane_parity(input logic [MAX_W-1:0] d);
    logic [MAX_W/LANE_W-1:0] p;
    for (int i = 0; i < MAX_W/LANE_W; i++) p[i] = ^d[i*LANE_W +: LANE_W];
    return p;
  endfunction
endpackage

// File: rtl/amber_mem_lane_merge.sv
// amber_mem_lane_merge: per-lane select of new vs old word under a lane enable mask
module amber_mem_lane_merge #(
  parameter int LANES = 6,
  parameter int LW = 8
) (
  input  logic [LANES*LW-1:0] old_word,
  input  logic [LANES*LW-1:0] new_word,
  input  logic [LANES-1:0]    be,
  output logic [LANES*LW-1:0] merged
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[i*LW +: LW] = be[i] ? new_word[i*LW +: LW] : old_word[i*LW +: LW];
  end
endmodule

// File: rtl/amber_mem_dp.sv
// amber_mem_dp: dual-port word memory with post-reset clear FSM; lane parity enabled by AMBER_MEM_PARITY_EN
module amber_mem_dp
  import amber_mem_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int WORDS = 16384,
  localparam int LANES = WIDTH / LANE_W,
  localparam int ADDR_W = WORDS > 1 ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  input  logic              a_req,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  output logic              a_perr,
  input  logic              b_req,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [LANES-1:0]  b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  output logic              b_perr
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_addr;
  logic [WIDTH-1:0] mem [WORDS];
  logic a_acc, b_acc, b_wr, b_rd, a_in, b_in, a_fwd, a_perr_nx, b_perr_nx;
  logic [WIDTH-1:0] a_old, b_old, a_merged, b_merged;
  assign busy = state == CLEAR;
  assign a_ready = !busy;
  assign b_ready = !busy;
  assign a_acc = a_req & a_ready;
  assign b_acc = b_req & b_ready;
  assign a_in = {1'b0, a_addr} < (ADDR_W+1)'(WORDS);
  assign b_in = {1'b0, b_addr} < (ADDR_W+1)'(WORDS);
  assign b_wr = b_acc & b_we & b_in;
  assign b_rd = b_acc & ~b_we;
  assign a_old = a_in ? mem[a_addr] : '0;
  assign b_old = b_in ? mem[b_addr] : '0;
  assign a_fwd = b_wr & a_in & (a_addr == b_addr);
  amber_mem_lane_merge #(.LANES(LANES), .LW(LANE_W)) u_wr_merge (
    .old_word(b_old), .new_word(b_wdata), .be(b_be), .merged(b_merged)
  );
  amber_mem_lane_merge #(.LANES(LANES), .LW(LANE_W)) u_fwd_merge (
    .old_word(a_old), .new_word(b_wdata), .be(b_be), .merged(a_merged)
  );
  always_comb state_nx = (busy && clr_addr == ADDR_W'(WORDS-1)) ? RUN : state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nx;
      if (busy) clr_addr <= clr_addr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (busy) mem[clr_addr] <= '0;
    else if (rst_n && b_wr) mem[b_addr] <= b_merged;
  end
`ifdef AMBER_MEM_PARITY_EN
  logic [LANES-1:0] par [WORDS];
  logic [LANES-1:0] a_par_old, b_par_old, b_par_new, b_par_merged;
  assign a_par_old = a_in ? par[a_addr] : '0;
  assign b_par_old = b_in ? par[b_addr] : '0;
  assign b_par_new = LANES'(lane_parity(MAX_W'(b_wdata)));
  amber_mem_lane_merge #(.LANES(LANES), .LW(1)) u_par_merge (
    .old_word(b_par_old), .new_word(b_par_new), .be(b_be), .merged(b_par_merged)
  );
  assign a_perr_nx = !a_fwd && |(LANES'(lane_parity(MAX_W'(a_old))) ^ a_par_old);
  assign b_perr_nx = |(LANES'(lane_parity(MAX_W'(b_old))) ^ b_par_old);
  always_ff @(posedge clk) begin
    if (busy) par[clr_addr] <= '0;
    else if (rst_n && b_wr) par[b_addr] <= b_par_merged;
  end
`else
  assign a_perr_nx = 1'b0;
  assign b_perr_nx = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      a_rdata <= '0;
      a_perr <= 1'b0;
      b_rvalid <= 1'b0;
      b_rdata <= '0;
      b_perr <= 1'b0;
    end else begin
      a_rvalid <= a_acc;
      b_rvalid <= b_rd;
      if (a_acc) begin
        a_rdata <= a_fwd ? a_merged : a_old;
        a_perr <= a_perr_nx;
      end
      if (b_rd) begin
        b_rdata <= b_old;
        b_perr <= b_perr_nx;
      end
    end
  end
endmodule

// File: tb/tb_amber_mem_dp.sv
// tb_amber_mem_dp: directed and random checks of 16- and 12-word amber_mem_dp instances against an array model
module tb_amber_mem_dp;
`ifdef AMBER_MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst16, rst12;
  logic a_req, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [5:0] b_be;
  logic [47:0] b_wdata;
  logic busy [2], a_ready [2], b_ready [2], a_rvalid [2], b_rvalid [2], a_perr [2], b_perr [2];
  logic [47:0] a_rdata [2], b_rdata [2];
  logic [47:0] mm [2][16];
  logic [47:0] ea_d [2], eb_d [2];
  logic ea_v [2], eb_v [2], ea_p [2], eb_p [2];
  logic cor2;
  int dep [2] = '{16, 12};
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  amber_mem_dp #(.WIDTH(48), .WORDS(16)) u16 (
    .clk(clk), .rst_n(rst16), .busy(busy[0]),
    .a_req(a_req), .a_ready(a_ready[0]), .a_addr(a_addr), .a_rvalid(a_rvalid[0]),
    .a_rdata(a_rdata[0]), .a_perr(a_perr[0]),
    .b_req(b_req), .b_ready(b_ready[0]), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]), .b_perr(b_perr[0])
  );
  amber_mem_dp #(.WIDTH(48), .WORDS(12)) u12 (
    .clk(clk), .rst_n(rst12), .busy(busy[1]),
    .a_req(a_req), .a_ready(a_ready[1]), .a_addr(a_addr), .a_rvalid(a_rvalid[1]),
    .a_rdata(a_rdata[1]), .a_perr(a_perr[1]),
    .b_req(b_req), .b_ready(b_ready[1]), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]), .b_perr(b_perr[1])
  );
  function automatic logic [47:0] mrg(input logic [47:0] o, input logic [47:0] n, input logic [5:0] be);
    for (int i = 0; i < 6; i++) if (be[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic reset_model(input int k);
    for (int a = 0; a < 16; a++) mm[k][a] = '0;
    ea_v[k] = 1'b0; eb_v[k] = 1'b0; ea_p[k] = 1'b0; eb_p[k] = 1'b0;
    ea_d[k] = '0; eb_d[k] = '0;
  endtask
  task automatic chk_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy%0d", k), 48'(busy[k]), 48'(0));
      check($sformatf("a_rvalid%0d", k), 48'(a_rvalid[k]), 48'(ea_v[k]));
      check($sformatf("a_rdata%0d", k), a_rdata[k], ea_d[k]);
      check($sformatf("a_perr%0d", k), 48'(a_perr[k]), 48'(ea_p[k]));
      check($sformatf("b_rvalid%0d", k), 48'(b_rvalid[k]), 48'(eb_v[k]));
      check($sformatf("b_rdata%0d", k), b_rdata[k], eb_d[k]);
      check($sformatf("b_perr%0d", k), 48'(b_perr[k]), 48'(eb_p[k]));
    end
  endtask
  task automatic idle();
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0; b_we = 1'b0; b_be = '0; a_addr = '0; b_addr = '0; b_wdata = '0;
  endtask
  task automatic cyc(input logic ar, input logic [3:0] aa, input logic br, input logic bw,
                     input logic [5:0] be, input logic [3:0] ba, input logic [47:0] wd);
    @(negedge clk);
    a_req = ar; a_addr = aa; b_req = br; b_we = bw; b_be = be; b_addr = ba; b_wdata = wd;
    for (int k = 0; k < 2; k++) begin
      logic wr;
      wr = br && bw && ba < dep[k];
      ea_v[k] = ar;
      if (ar) begin
        ea_d[k] = aa < dep[k] ? mm[k][aa] : '0;
        ea_p[k] = PAR && k == 0 && aa == 2 && cor2;
        if (wr && aa == ba) begin
          ea_d[k] = mrg(ea_d[k], wd, be);
          ea_p[k] = 1'b0;
        end
      end
      eb_v[k] = br && !bw;
      if (eb_v[k]) begin
        eb_d[k] = ba < dep[k] ? mm[k][ba] : '0;
        eb_p[k] = PAR && k == 0 && ba == 2 && cor2;
      end
      if (wr) mm[k][ba] = mrg(mm[k][ba], wd, be);
    end
    if (br && bw && ba == 2 && be[1]) cor2 = 1'b0;
    @(posedge clk);
    #1;
    chk_all();
  endtask
  initial begin
    cor2 = 1'b0;
    rst16 = 1'b0; rst12 = 1'b0;
    a_req = 1'b0; b_req = 1'b0; b_we = 1'b0; b_be = '0; a_addr = '0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_busy%0d", k), 48'(busy[k]), 48'(1));
      check($sformatf("rst_a_ready%0d", k), 48'(a_ready[k]), 48'(0));
      check($sformatf("rst_a_rvalid%0d", k), 48'(a_rvalid[k]), 48'(0));
      check($sformatf("rst_a_rdata%0d", k), a_rdata[k], 48'(0));
      check($sformatf("rst_b_rvalid%0d", k), 48'(b_rvalid[k]), 48'(0));
      check($sformatf("rst_b_rdata%0d", k), b_rdata[k], 48'(0));
      check($sformatf("rst_perr%0d", k), 48'({a_perr[k], b_perr[k]}), 48'(0));
    end
    @(negedge clk);
    rst16 = 1'b1; rst12 = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk);
      #1;
      check("clear_busy16", 48'(busy[0]), 48'(j < 16));
      check("clear_busy12", 48'(busy[1]), 48'(j < 12));
      check("clear_ready16", 48'({a_ready[0], b_ready[0]}), j < 16 ? 48'(0) : 48'(3));
      check("clear_ready12", 48'({a_ready[1], b_ready[1]}), j < 12 ? 48'(0) : 48'(3));
    end
    reset_model(0);
    reset_model(1);
    cyc(1'b1, 4'd5, 1'b0, 1'b0, 6'h00, 4'd0, 48'h0);
    check("t1_a_rvalid", 48'(a_rvalid[0]), 48'(1));
    check("t1_a_rdata", a_rdata[0], 48'h0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 6'h3F, 4'd3, 48'hA5A5_1234_5678);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 6'h00, 4'd3, 48'h0);
    check("t2_b_rdata", b_rdata[0], 48'hA5A5_1234_5678);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 6'h00, 4'd0, 48'h0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 6'b000001, 4'd3, 48'hFF);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 6'h00, 4'd3, 48'h0);
    check("t3_b_rdata", b_rdata[0], 48'hA5A5_1234_56FF);
    cyc(1'b1, 4'd7, 1'b1, 1'b1, 6'b110000, 4'd7, 48'hBEEF_0000_0000);
    check("t4_a_rdata", a_rdata[0], 48'hBEEF_0000_0000);
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 6'h3F, 4'd13, 48'h1234_5678_9ABC);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 6'h00, 4'd13, 48'h0);
    check("t5_b_rdata12", b_rdata[1], 48'h0);
    check("t5_b_rdata16", b_rdata[0], 48'h1234_5678_9ABC);
    for (int a = 0; a < 12; a++) cyc(1'b1, 4'(a), 1'b1, 1'b0, 6'h00, 4'(a), 48'h0);
    for (int n = 0; n < 400; n++)
      cyc(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 6'($urandom),
          4'($urandom), 48'({$urandom(), $urandom()}));
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 6'h3F, 4'd4, 48'h0000_DEAD_BEEF);
    idle();
    rst12 = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_busy12", 48'(busy[1]), 48'(1));
    check("t5_rst_rdata12", {b_rdata[1][23:0], a_rdata[1][23:0]}, 48'h0);
    @(negedge clk);
    rst12 = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk);
      #1;
      check("t5_clear_busy12", 48'(busy[1]), 48'(1));
    end
    @(negedge clk);
    rst12 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst12 = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      #1;
      check("t5_reclear_busy12", 48'(busy[1]), 48'(j < 12));
    end
    reset_model(1);
    ea_v[0] = 1'b0;
    eb_v[0] = 1'b0;
    cyc(1'b1, 4'd4, 1'b1, 1'b0, 6'h00, 4'd4, 48'h0);
    check("t5_cleared12", b_rdata[1], 48'h0);
    check("t5_kept16", b_rdata[0], 48'h0000_DEAD_BEEF);
    @(negedge clk);
    u16.mem[2][9] = ~u16.mem[2][9];
    mm[0][2][9] = ~mm[0][2][9];
    cor2 = 1'b1;
    cyc(1'b1, 4'd2, 1'b1, 1'b0, 6'h00, 4'd2, 48'h0);
    check("t6_b_perr", 48'({b_rvalid[0], b_perr[0]}), 48'({1'b1, PAR}));
    check("t6_a_perr", 48'({a_rvalid[0], a_perr[0]}), 48'({1'b1, PAR}));
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 6'h3F, 4'd2, 48'h0F0F_0F0F_0F0F);
    cyc(1'b1, 4'd2, 1'b1, 1'b0, 6'h00, 4'd2, 48'h0);
    check("t6_b_perr_fixed", 48'(b_perr[0]), 48'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
